// File: rtl/bambu_mem_model_pkg.sv
// Shared types and helpers for the bambu memory model: access decode,
// address window test, size-to-mask conversion and default delays.
package bambu_mem_model_pkg;

  localparam int unsigned DEF_RD_DELAY = 2;
  localparam int unsigned DEF_WR_DELAY = 1;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned MAX_DATA_W   = 1024;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_READ,
    ACC_WRITE,
    ACC_ERR
  } access_e;

  function automatic logic in_range(int unsigned addr, int unsigned base, int unsigned size);
    return (addr >= base) && (addr < base + size);
  endfunction

  // Size 0 or a size covering the whole word selects every bit.
  function automatic logic [MAX_DATA_W-1:0] size_mask(int unsigned size, int unsigned data_w);
    if (size == 0 || size >= data_w) return '1;
    return (MAX_DATA_W'(1) << size) - MAX_DATA_W'(1);
  endfunction

  // Conflicting oe/we is flagged even for addresses outside the window.
  function automatic access_e decode_access(logic oe, logic we, logic hit);
    if (oe && we) return ACC_ERR;
    if (!hit)     return ACC_NONE;
    if (oe)       return ACC_READ;
    if (we)       return ACC_WRITE;
    return ACC_NONE;
  endfunction

endpackage

// File: rtl/bambu_mem_model_if.sv
// Multi-channel memory bus between the master(s) and bambu_mem_model,
// including the full-word preload port.
interface bambu_mem_model_if #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned SIZE_W = $clog2(DATA_W) + 1;

  logic [N_CH-1:0]        Mout_oe_ram;
  logic [N_CH-1:0]        Mout_we_ram;
  logic [N_CH*ADDR_W-1:0] Mout_addr_ram;
  logic [N_CH*DATA_W-1:0] Mout_Wdata_ram;
  logic [N_CH*SIZE_W-1:0] Mout_data_ram_size;
  logic                   init_we;
  logic [ADDR_W-1:0]      init_addr;
  logic [DATA_W-1:0]      init_data;
  logic [N_CH*DATA_W-1:0] M_Rdata_ram;
  logic [N_CH-1:0]        M_DataRdy;
  logic [N_CH-1:0]        err_oe_we;

  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    output init_we, init_addr, init_data,
    input  M_Rdata_ram, M_DataRdy, err_oe_we
  );

  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    input  init_we, init_addr, init_data,
    output M_Rdata_ram, M_DataRdy, err_oe_we
  );

endinterface

// File: rtl/bambu_mem_channel.sv
// One memory channel: held-cycle counter, read sampling pipeline,
// completion strobe and sticky oe/we conflict flag.
module bambu_mem_channel
  import bambu_mem_model_pkg::*;
#(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEMSIZE   = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned RD_DELAY  = DEF_RD_DELAY,
  parameter int unsigned WR_DELAY  = DEF_WR_DELAY
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              oe_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              data_rdy_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              wr_commit_o,
  output logic              err_o
);

  localparam int unsigned     NSTG    = RD_DELAY - 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_DELAY - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_DELAY - 1);

  access_e           acc;
  logic              done;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] pipe_q [NSTG];

  always_comb begin
    acc  = decode_access(oe_i, we_i, in_range(32'(addr_i), BASE_ADDR, MEMSIZE));
    done = 1'b0;
    unique case (acc)
      ACC_READ:  done = (cnt_q == RD_LAST);
      ACC_WRITE: done = (cnt_q == WR_LAST);
      default:   done = 1'b0;
    endcase
    cnt_d = ((acc == ACC_READ || acc == ACC_WRITE) && !done) ? cnt_q + CNT_W'(1) : '0;
    err_d = err_q | (acc == ACC_ERR);
  end

  // Strobe is combinational so WR_DELAY=1 completes in the request cycle;
  // gating with reset keeps outputs quiet for the whole reset window.
  assign data_rdy_o  = done & rst_ni;
  assign wr_commit_o = data_rdy_o && (acc == ACC_WRITE);
  assign rdata_o     = (data_rdy_o && acc == ACC_READ) ? pipe_q[NSTG-1] : '0;
  assign err_o       = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int unsigned s = 0; s < NSTG; s++) pipe_q[s] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      pipe_q[0] <= mem_rdata_i;
      for (int unsigned s = 1; s < NSTG; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

endmodule

// File: rtl/bambu_mem_model.sv
// Multi-channel behavioural memory with per-channel read/write latency.
// Optional BAMBU_MEM_BYTE_MASK_EN: writes touch only bits [size-1:0].
module bambu_mem_model
  import bambu_mem_model_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEMSIZE   = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned RD_DELAY  = DEF_RD_DELAY,
  parameter int unsigned WR_DELAY  = DEF_WR_DELAY
) (
  input logic               clock,
  input logic               reset,
  bambu_mem_model_if.slave  bus
);

  localparam int unsigned SIZE_W = $clog2(DATA_W) + 1;
  localparam int unsigned IDX_W  = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

  logic [DATA_W-1:0]      mem_q [MEMSIZE];
  logic [N_CH*DATA_W-1:0] rd_word;
  logic [N_CH*DATA_W-1:0] wr_word;
  logic [N_CH*DATA_W-1:0] rdata;
  logic [N_CH-1:0]        rdy, commit, err;

  function automatic logic [IDX_W-1:0] word_idx(logic [ADDR_W-1:0] a);
    return IDX_W'(32'(a) - BASE_ADDR);
  endfunction

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (in_range(32'(bus.Mout_addr_ram[i*ADDR_W +: ADDR_W]), BASE_ADDR, MEMSIZE))
        rd_word[i*DATA_W +: DATA_W] = mem_q[word_idx(bus.Mout_addr_ram[i*ADDR_W +: ADDR_W])];
    end
  end

`ifdef BAMBU_MEM_BYTE_MASK_EN
  always_comb begin
    logic [DATA_W-1:0] m;
    wr_word = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      m = DATA_W'(size_mask(32'(bus.Mout_data_ram_size[i*SIZE_W +: SIZE_W]), DATA_W));
      wr_word[i*DATA_W +: DATA_W] = (rd_word[i*DATA_W +: DATA_W] & ~m) |
                                    (bus.Mout_Wdata_ram[i*DATA_W +: DATA_W] & m);
    end
  end
`else
  logic unused_size;
  assign unused_size = ^bus.Mout_data_ram_size;
  assign wr_word     = bus.Mout_Wdata_ram;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    bambu_mem_channel #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MEMSIZE  (MEMSIZE),
      .BASE_ADDR(BASE_ADDR),
      .RD_DELAY (RD_DELAY),
      .WR_DELAY (WR_DELAY)
    ) u_ch (
      .clk_i      (clock),
      .rst_ni     (reset),
      .oe_i       (bus.Mout_oe_ram[i]),
      .we_i       (bus.Mout_we_ram[i]),
      .addr_i     (bus.Mout_addr_ram[i*ADDR_W +: ADDR_W]),
      .mem_rdata_i(rd_word[i*DATA_W +: DATA_W]),
      .data_rdy_o (rdy[i]),
      .rdata_o    (rdata[i*DATA_W +: DATA_W]),
      .wr_commit_o(commit[i]),
      .err_o      (err[i])
    );
  end

  assign bus.M_DataRdy   = rdy;
  assign bus.M_Rdata_ram = rdata;
  assign bus.err_oe_we   = err;

  // Storage survives reset; later NBAs win, so higher channels then init have priority.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (commit[i])
        mem_q[word_idx(bus.Mout_addr_ram[i*ADDR_W +: ADDR_W])] <= wr_word[i*DATA_W +: DATA_W];
    end
    if (bus.init_we && in_range(32'(bus.init_addr), BASE_ADDR, MEMSIZE))
      mem_q[word_idx(bus.init_addr)] <= bus.init_data;
  end

endmodule
